// File: rtl/pkt_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : pkt_dispatch
// Brief    : Store-and-forward demux of executed packets onto CPU-up and
//            port-down channels; packets marked invalid are flushed.
// Revision : 1.0
// ============================================================================
module pkt_dispatch #(
   parameter int DFIFO_AW    = 8,
   parameter int VFIFO_AW    = 6,
   parameter int ALF_THRESH  = 128,
   parameter int VALF_THRESH = 56
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         exe2disp_direction_req,
   input  logic         exe2disp_direction,
   input  logic         exe2disp_data_wr,
   input  logic [133:0] exe2disp_data,
   input  logic         exe2disp_valid_wr,
   input  logic         exe2disp_valid,
   output logic         disp2exe_alf,
   output logic         disp2up_data_wr,
   output logic [133:0] disp2up_data,
   output logic         disp2up_valid_wr,
   output logic         disp2up_valid,
   input  logic         up2disp_alf,
   output logic         disp2down_data_wr,
   output logic [133:0] disp2down_data,
   output logic         disp2down_valid_wr,
   output logic         disp2down_valid,
   input  logic         down2disp_alf,
   output logic         disp_err
);
   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_send   = 2'd1;
   localparam logic [1:0] c_st_drop   = 2'd2;
   localparam logic [1:0] c_site_head = 2'b01;
   localparam logic [1:0] c_site_tail = 2'b10;
   localparam logic [DFIFO_AW:0] c_dfull = {1'b1, {DFIFO_AW{1'b0}}};
   localparam logic [VFIFO_AW:0] c_vfull = {1'b1, {VFIFO_AW{1'b0}}};
   localparam logic [DFIFO_AW:0] c_alf   = ALF_THRESH[DFIFO_AW:0];
   localparam logic [VFIFO_AW:0] c_valf  = VALF_THRESH[VFIFO_AW:0];

   logic [1:0]   w_site;
   logic         w_is_head, w_is_tail, w_wsel, w_word_ok;
   logic         w_dfull_sel, w_vfull_sel, w_err;
   logic [1:0]   w_dfull, w_vfull, w_dhi, w_vhi, w_dpush, w_vpush;
   logic [1:0]   w_cons_alf, w_out_wr, w_out_vwr;
   logic [133:0] w_out_data [2];
   logic         r_in_pkt, r_dir_lat, r_chan_lat, r_err, r_alf;

   assign w_cons_alf = {down2disp_alf, up2disp_alf};

   always_comb begin
      w_site      = exe2disp_data[133:132];
      w_is_head   = (w_site == c_site_head);
      w_is_tail   = (w_site == c_site_tail);
      // The head never trusts the live direction; it may already be moving.
      w_wsel      = w_is_head ? r_dir_lat : r_chan_lat;
      w_word_ok   = exe2disp_data_wr && (r_in_pkt || w_is_head);
      w_dfull_sel = w_dfull[w_wsel];
      w_vfull_sel = w_vfull[r_chan_lat];
      w_dpush     = 2'b00;
      if (w_word_ok && !w_dfull_sel) w_dpush[w_wsel] = 1'b1;
      w_vpush     = 2'b00;
      if (exe2disp_valid_wr && !w_vfull_sel) w_vpush[r_chan_lat] = 1'b1;
      // Stray non-head outside a packet, or a head that cuts off an open packet.
      w_err = (exe2disp_data_wr && (r_in_pkt == w_is_head)) ||
              (w_word_ok && w_dfull_sel) ||
              (exe2disp_valid_wr && w_vfull_sel);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_pkt   <= 1'b0;
         r_dir_lat  <= 1'b0;
         r_chan_lat <= 1'b0;
         r_err      <= 1'b0;
         r_alf      <= 1'b0;
      end else begin
         r_err <= w_err;
         r_alf <= (|w_dhi) || (|w_vhi);
         if (!r_in_pkt && !exe2disp_data_wr && exe2disp_direction_req)
            r_dir_lat <= exe2disp_direction;
         if (exe2disp_data_wr) begin
            if (w_is_head) begin
               r_in_pkt   <= 1'b1;
               r_chan_lat <= r_dir_lat;
            end else if (w_is_tail) begin
               r_in_pkt <= 1'b0;
            end
         end
      end
   end

   for (genvar c = 0; c < 2; c++) begin : g_chan
      logic [133:0]        r_mem  [0:(1<<DFIFO_AW)-1];
      logic                r_vmem [0:(1<<VFIFO_AW)-1];
      logic [DFIFO_AW-1:0] r_dwr, r_drd;
      logic [DFIFO_AW:0]   r_dcnt;
      logic [VFIFO_AW-1:0] r_vwr, r_vrd;
      logic [VFIFO_AW:0]   r_vcnt;
      logic [1:0]          r_state, w_state_nx;
      logic [133:0]        r_word, w_head_word;
      logic                w_dpop, w_vpop, w_dempty, w_vempty;

      assign w_head_word = r_mem[r_drd];
      assign w_dempty    = (r_dcnt == '0);
      assign w_vempty    = (r_vcnt == '0);
      assign w_dfull[c]  = (r_dcnt == c_dfull);
      assign w_vfull[c]  = (r_vcnt == c_vfull);
      assign w_dhi[c]    = (r_dcnt >= c_alf);
      assign w_vhi[c]    = (r_vcnt >= c_valf);

      always_comb begin
         w_state_nx = r_state;
         w_dpop     = 1'b0;
         w_vpop     = 1'b0;
         case (r_state)
            c_st_idle: begin
               if (!w_vempty) begin
                  if (!r_vmem[r_vrd]) begin
                     w_vpop     = 1'b1;
                     w_state_nx = c_st_drop;
                  end else if (!w_cons_alf[c]) begin
                     w_vpop     = 1'b1;
                     w_dpop     = !w_dempty;
                     w_state_nx = c_st_send;
                  end
               end
            end
            c_st_send: begin
               if (r_word[133:132] == c_site_tail) w_state_nx = c_st_idle;
               else                                w_dpop     = !w_dempty;
            end
            c_st_drop: begin
               if (!w_dempty) begin
                  w_dpop = 1'b1;
                  if (w_head_word[133:132] == c_site_tail) w_state_nx = c_st_idle;
               end
            end
            default: w_state_nx = c_st_idle;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_state <= c_st_idle;
            r_dwr   <= '0;
            r_drd   <= '0;
            r_dcnt  <= '0;
            r_vwr   <= '0;
            r_vrd   <= '0;
            r_vcnt  <= '0;
            r_word  <= '0;
         end else begin
            r_state <= w_state_nx;
            if (w_dpush[c]) r_dwr <= r_dwr + DFIFO_AW'(1);
            if (w_dpop) begin
               r_drd  <= r_drd + DFIFO_AW'(1);
               r_word <= w_head_word;
            end
            r_dcnt <= r_dcnt + {{DFIFO_AW{1'b0}}, w_dpush[c]} - {{DFIFO_AW{1'b0}}, w_dpop};
            if (w_vpush[c]) r_vwr <= r_vwr + VFIFO_AW'(1);
            if (w_vpop)     r_vrd <= r_vrd + VFIFO_AW'(1);
            r_vcnt <= r_vcnt + {{VFIFO_AW{1'b0}}, w_vpush[c]} - {{VFIFO_AW{1'b0}}, w_vpop};
         end
      end

      always_ff @(posedge clk) begin
         if (w_dpush[c]) r_mem[r_dwr]  <= exe2disp_data;
         if (w_vpush[c]) r_vmem[r_vwr] <= exe2disp_valid;
      end

      assign w_out_wr[c]   = (r_state == c_st_send);
      assign w_out_vwr[c]  = w_out_wr[c] && (r_word[133:132] == c_site_tail);
      assign w_out_data[c] = w_out_wr[c] ? r_word : '0;
   end

   assign disp2exe_alf       = r_alf;
   assign disp_err           = r_err;
   assign disp2up_data_wr    = w_out_wr[0];
   assign disp2up_data       = w_out_data[0];
   assign disp2up_valid_wr   = w_out_vwr[0];
   assign disp2up_valid      = w_out_vwr[0];
   assign disp2down_data_wr  = w_out_wr[1];
   assign disp2down_data     = w_out_data[1];
   assign disp2down_valid_wr = w_out_vwr[1];
   assign disp2down_valid    = w_out_vwr[1];
endmodule
`default_nettype wire
